// File: rtl/alu_lane_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_lane_sequencer
// Brief    : Runs one masked vector ALU operation through a shared scalar
//            ALU, one enabled lane per cycle, and returns the assembled vector.
// Revision : 1.0 - initial release
// ============================================================================
module alu_lane_sequencer #(
    parameter int DATA_WIDTH = 8,
    parameter int LANES      = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [2:0]                  req_op,
    input  logic [LANES*DATA_WIDTH-1:0] req_a,
    input  logic [LANES*DATA_WIDTH-1:0] req_b,
    input  logic [LANES-1:0]            req_mask,
    output logic [2:0]                  alu_op,
    output logic [DATA_WIDTH-1:0]       alu_a,
    output logic [DATA_WIDTH-1:0]       alu_b,
    input  logic [DATA_WIDTH-1:0]       alu_result,
    input  logic                        alu_neg,
    input  logic                        alu_zero,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [LANES*DATA_WIDTH-1:0] rsp_result,
    output logic                        rsp_zero,
    output logic                        rsp_neg,
    output logic [LANES-1:0]            rsp_lane_neg
);

    localparam int         c_LW       = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_EXEC  = 2'd1;
    localparam logic [1:0] c_ST_DONE  = 2'd2;

    logic [1:0]                  r_state;
    logic [2:0]                  r_op;
    logic [LANES*DATA_WIDTH-1:0] r_a;
    logic [LANES*DATA_WIDTH-1:0] r_b;
    logic [LANES-1:0]            r_mask;
    logic [c_LW-1:0]             r_lane;
    logic [LANES*DATA_WIDTH-1:0] r_result;
    logic [LANES-1:0]            r_lane_neg;
    logic [LANES-1:0]            r_lane_zero;
    logic                        r_flags_valid;

    logic [c_LW-1:0]             w_first_lane;
    logic [c_LW-1:0]             w_next_lane;
    logic                        w_has_next;
    logic                        w_exec;

    // Downward scans leave the lowest qualifying lane as the final assignment.
    always_comb begin
        w_first_lane = '0;
        w_next_lane  = '0;
        w_has_next   = 1'b0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (req_mask[i]) begin
                w_first_lane = c_LW'(i);
            end
            if (r_mask[i] && (i > int'(r_lane))) begin
                w_next_lane = c_LW'(i);
                w_has_next  = 1'b1;
            end
        end
    end

    assign w_exec       = (r_state == c_ST_EXEC);
    assign req_ready    = (r_state == c_ST_IDLE);
    assign rsp_valid    = (r_state == c_ST_DONE);
    assign alu_op       = w_exec ? r_op : 3'b000;
    assign alu_a        = w_exec ? r_a[r_lane*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign alu_b        = w_exec ? r_b[r_lane*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign rsp_result   = r_result;
    assign rsp_lane_neg = r_lane_neg;
    assign rsp_neg      = |r_lane_neg;
    // Disabled lanes count as zero so an empty mask reports zero; gated to 0 out of reset.
    assign rsp_zero     = r_flags_valid & (&(r_lane_zero | ~r_mask));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= c_ST_IDLE;
            r_op          <= '0;
            r_a           <= '0;
            r_b           <= '0;
            r_mask        <= '0;
            r_lane        <= '0;
            r_result      <= '0;
            r_lane_neg    <= '0;
            r_lane_zero   <= '0;
            r_flags_valid <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (req_valid) begin
                        r_op          <= req_op;
                        r_a           <= req_a;
                        r_b           <= req_b;
                        r_mask        <= req_mask;
                        r_result      <= req_a;
                        r_lane_neg    <= '0;
                        r_lane_zero   <= '0;
                        r_flags_valid <= 1'b1;
                        r_lane        <= w_first_lane;
                        r_state       <= (req_mask == '0) ? c_ST_DONE : c_ST_EXEC;
                    end
                end
                c_ST_EXEC: begin
                    r_result[r_lane*DATA_WIDTH +: DATA_WIDTH] <= alu_result;
                    r_lane_neg[r_lane]  <= alu_neg;
                    r_lane_zero[r_lane] <= alu_zero;
                    if (w_has_next) begin
                        r_lane <= w_next_lane;
                    end else begin
                        r_state <= c_ST_DONE;
                    end
                end
                c_ST_DONE: begin
                    if (rsp_ready) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
